// File: rtl/video_pkg.sv
// video_pkg: default timing, axis timing struct, IRQ state encoding and total-length helper
package video_pkg;
  localparam int H_ACTIVE_DEF = 256;
  localparam int H_FP_DEF     = 32;
  localparam int H_SYNC_DEF   = 32;
  localparam int H_BP_DEF     = 64;
  localparam int V_ACTIVE_DEF = 224;
  localparam int V_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 8;
  localparam int V_BP_DEF     = 16;
  localparam int PIX_DIV_DEF  = 8;
  localparam int IRQ_LINE_DEF = 224;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vtg_timing_t;
  // IDLE encodes as 1 so the state flop drives irq_n directly
  typedef enum logic {PEND = 1'b0, IDLE = 1'b1} irq_state_t;
  function automatic int unsigned vtg_total(vtg_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: timing outputs and IRQ acknowledge of video_timing_gen
interface video_timing_gen_if #(parameter int HW = 9, parameter int VW = 9);
  logic irq_ack, pix_ce, hsync, vsync, csync_n, hblank, vblank, de, line_start, frame_start, irq_n;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  modport master (input irq_ack, output pix_ce, hcount, vcount, hsync, vsync, csync_n,
                  hblank, vblank, de, line_start, frame_start, irq_n);
  modport slave (output irq_ack, input pix_ce, hcount, vcount, hsync, vsync, csync_n,
                 hblank, vblank, de, line_start, frame_start, irq_n);
endinterface

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one timing axis -- position counter, wrap strobe, blank/sync decode of the next position
module vtg_axis_counter import video_pkg::*; #(
  parameter vtg_timing_t T = '{active: H_ACTIVE_DEF, fp: H_FP_DEF, sync: H_SYNC_DEF, bp: H_BP_DEF},
  parameter int W = $clog2(vtg_total(T))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         blank_nxt,
  output logic         sync_nxt
);
  localparam int TOT = vtg_total(T);
  localparam int S0 = T.active + T.fp;
  logic [W-1:0] count_q, count_d;
  // decode the value the counter is about to take so the caller's flags land with it
  always_comb begin
    wrap = en && count_q == W'(TOT - 1);
    count_d = wrap ? '0 : en ? count_q + 1'b1 : count_q;
    blank_nxt = count_d >= W'(T.active);
    sync_nxt = count_d >= W'(S0) && count_d < W'(S0 + T.sync);
  end
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with pixel divider and vblank IRQ
// `define VTG_IRQ_EN to build the IRQ state machine; otherwise irq_n is tied high
module video_timing_gen import video_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIX_DIV  = PIX_DIV_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int IRQ_LINE = IRQ_LINE_DEF
) (
  input logic clk,
  input logic rst,
  video_timing_gen_if.master vif
);
  localparam vtg_timing_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vtg_timing_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL = vtg_total(HT);
  localparam int V_TOTAL = vtg_total(VT);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  if (PIX_DIV < 1 || IRQ_LINE < 0 || IRQ_LINE >= V_TOTAL || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
    $fatal(1, "video_timing_gen: illegal timing configuration");
  end
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic tick, h_wrap, v_wrap, h_blank_nxt, h_sync_nxt, v_blank_nxt, v_sync_nxt;
  logic pix_ce_q, pix_ce_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, csync_n_q, csync_n_d;
  assign tick = div_q == DW'(PIX_DIV - 1);
  vtg_axis_counter #(.T(HT), .W(HW)) u_h (.clk(clk), .rst(rst), .en(tick), .count(h_count),
    .wrap(h_wrap), .blank_nxt(h_blank_nxt), .sync_nxt(h_sync_nxt));
  vtg_axis_counter #(.T(VT), .W(VW)) u_v (.clk(clk), .rst(rst), .en(h_wrap), .count(v_count),
    .wrap(v_wrap), .blank_nxt(v_blank_nxt), .sync_nxt(v_sync_nxt));
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    pix_ce_d = tick;
    line_start_d = h_wrap;
    frame_start_d = v_wrap;
    hblank_d = h_blank_nxt;
    vblank_d = v_blank_nxt;
    de_d = ~h_blank_nxt & ~v_blank_nxt;
    hsync_d = HS_POL ? h_sync_nxt : ~h_sync_nxt;
    vsync_d = VS_POL ? v_sync_nxt : ~v_sync_nxt;
    csync_n_d = ~(h_sync_nxt | v_sync_nxt);
  end
  always_ff @(posedge clk)
    if (rst) begin
      div_q <= '0;
      pix_ce_q <= 1'b0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      de_q <= 1'b1;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      csync_n_q <= 1'b1;
    end else begin
      div_q <= div_d;
      pix_ce_q <= pix_ce_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      csync_n_q <= csync_n_d;
    end
`ifdef VTG_IRQ_EN
  // raise when the line counter is about to step onto IRQ_LINE; a raise beats a coincident ack
  localparam int IRQ_PREV = IRQ_LINE == 0 ? V_TOTAL - 1 : IRQ_LINE - 1;
  irq_state_t irq_q, irq_d;
  always_comb irq_d = (h_wrap && v_count == VW'(IRQ_PREV)) ? PEND : vif.irq_ack ? IDLE : irq_q;
  always_ff @(posedge clk)
    if (rst) irq_q <= IDLE;
    else irq_q <= irq_d;
  assign vif.irq_n = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = vif.irq_ack;
  assign vif.irq_n = 1'b1;
`endif
  assign vif.pix_ce = pix_ce_q;
  assign vif.hcount = h_count;
  assign vif.vcount = v_count;
  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
  assign vif.csync_n = csync_n_q;
  assign vif.hblank = hblank_q;
  assign vif.vblank = vblank_q;
  assign vif.de = de_q;
  assign vif.line_start = line_start_q;
  assign vif.frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench; two small-raster DUTs checked every clk against a time-based model
module tb_video_timing_gen;
  typedef struct packed {
    logic pix_ce;
    logic [3:0] hcount, vcount;
    logic hsync, vsync, csync_n, hblank, vblank, de, line_start, frame_start, irq_n;
  } outs_t;
  typedef struct packed { outs_t a, b; } pair_t;
  typedef struct {
    int pd, ha, hf, hs, hb, va, vf, vs, vb, il;
    bit hp, vp;
  } cfg_t;
  cfg_t ca = '{pd: 3, ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1, il: 6, hp: 1'b0, vp: 1'b1};
  cfg_t cb = '{pd: 1, ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1, il: 0, hp: 1'b1, vp: 1'b0};
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, fails = 0, t = 0;
  bit pa = 1'b0, pb = 1'b0;
  pair_t q[$];
  pair_t e;
  outs_t got_a, got_b;
  video_timing_gen_if #(.HW(4), .VW(4)) vif_a ();
  video_timing_gen_if #(.HW(4), .VW(4)) vif_b ();
  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .PIX_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .IRQ_LINE(6))
    u_dut_a (.clk(clk), .rst(rst), .vif(vif_a));
  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .PIX_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .IRQ_LINE(0))
    u_dut_b (.clk(clk), .rst(rst), .vif(vif_b));
  always #5 clk = ~clk;
  // position is derived purely from clk edges elapsed since reset release
  function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
  function automatic int hpos(cfg_t c, int tt); return (tt / c.pd) % htot(c); endfunction
  function automatic int vpos(cfg_t c, int tt); return ((tt / c.pd) / htot(c)) % vtot(c); endfunction
  function automatic bit raise(cfg_t c, int tt);
    return tt > 0 && tt % c.pd == 0 && hpos(c, tt) == 0 && vpos(c, tt) == c.il;
  endfunction
  function automatic outs_t expect_o(cfg_t c, int tt, bit pend);
    outs_t o;
    int h, v;
    bit h_act, v_act;
    h = hpos(c, tt);
    v = vpos(c, tt);
    h_act = h >= c.ha + c.hf && h < c.ha + c.hf + c.hs;
    v_act = v >= c.va + c.vf && v < c.va + c.vf + c.vs;
    o.pix_ce = tt > 0 && tt % c.pd == 0;
    o.hcount = 4'(h);
    o.vcount = 4'(v);
    o.hsync = c.hp ? h_act : !h_act;
    o.vsync = c.vp ? v_act : !v_act;
    o.csync_n = !(h_act || v_act);
    o.hblank = h >= c.ha;
    o.vblank = v >= c.va;
    o.de = !o.hblank && !o.vblank;
    o.line_start = o.pix_ce && h == 0;
    o.frame_start = o.line_start && v == 0;
    o.irq_n = !pend;
    return o;
  endfunction
  task automatic step(bit r, bit a);
    @(negedge clk);
    rst = r;
    vif_a.irq_ack = a;
    vif_b.irq_ack = a;
    @(posedge clk);
    if (r) begin
      t = 0;
      pa = 1'b0;
      pb = 1'b0;
    end else begin
      t++;
`ifdef VTG_IRQ_EN
      pa = raise(ca, t) ? 1'b1 : a ? 1'b0 : pa;
      pb = raise(cb, t) ? 1'b1 : a ? 1'b0 : pb;
`endif
    end
    q.push_back('{a: expect_o(ca, t, pa), b: expect_o(cb, t, pb)});
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      got_a = {vif_a.pix_ce, vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync, vif_a.csync_n,
               vif_a.hblank, vif_a.vblank, vif_a.de, vif_a.line_start, vif_a.frame_start, vif_a.irq_n};
      got_b = {vif_b.pix_ce, vif_b.hcount, vif_b.vcount, vif_b.hsync, vif_b.vsync, vif_b.csync_n,
               vif_b.hblank, vif_b.vblank, vif_b.de, vif_b.line_start, vif_b.frame_start, vif_b.irq_n};
      checks += 2;
      if (got_a !== e.a) begin
        fails++;
        $display("FAIL dut_a_outputs t=%0d got %p required %p", t, got_a, e.a);
      end
      if (got_b !== e.b) begin
        fails++;
        $display("FAIL dut_b_outputs t=%0d got %p required %p", t, got_b, e.b);
      end
    end
  initial begin
    vif_a.irq_ack = 1'b0;
    vif_b.irq_ack = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    repeat (1200) step(1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, raise(ca, t + 1) || $urandom_range(0, 19) == 0);
    for (int i = 0; i < 1000 && !(vpos(ca, t) == 4 && hpos(ca, t) == 5); i++) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 499) == 0, $urandom_range(0, 24) == 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left %0d required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 256: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 32: horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 32: hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 64: horizontal back-porch pixels (H_TOTAL = 384).
REQ-005 SHALL have parameter V_ACTIVE, default 224: visible lines.
REQ-006 SHALL have parameter V_FP, default 16: vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 8: vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 16: vertical back-porch lines (V_TOTAL = 264).
REQ-009 SHALL have parameter PIX_DIV, default 8: clk cycles per pixel, minimum 1.
REQ-010 SHALL have parameters HS_POL and VS_POL, default 0: sync active level (0 = active-low).
REQ-011 SHALL have parameter IRQ_LINE, default 224: vcount value at which the IRQ is raised.
REQ-012 clk  input  1  system clock; the only clock.
REQ-013 rst  input  1  reset; synchronous and active-high.
REQ-014 irq_ack  input  1  one-cycle acknowledge that clears irq_n.
REQ-015 pix_ce  output  1  pixel-clock enable, high one clk per pixel.
REQ-016 hcount  output  HW  pixel counter, HW = $clog2(H_TOTAL).
REQ-017 vcount  output  VW  line counter, VW = $clog2(V_TOTAL).
REQ-018 hsync, vsync  output  1 each  syncs at the configured polarity.
REQ-019 csync_n  output  1  composite sync, active-low (low when either sync is active).
REQ-020 hblank, vblank, de  output  1 each  blanking flags and display enable (de = ~hblank & ~vblank).
REQ-021 line_start, frame_start  output  1 each  one-pix_ce strobes at hcount==0, and at hcount==0 with vcount==0.
REQ-022 irq_n  output  1  active-low vblank interrupt.

Function
REQ-023 The divider SHALL count 0..PIX_DIV-1 and assert pix_ce on terminal count; with PIX_DIV=1, pix_ce SHALL be held high.
REQ-024 hcount SHALL advance only on pix_ce, counting 0..H_TOTAL-1, then wrap to 0.
REQ-025 vcount SHALL advance on the pix_ce in which hcount wraps, counting 0..V_TOTAL-1, then wrap to 0.
REQ-026 hblank SHALL be high for hcount >= H_ACTIVE.
REQ-027 The hsync-active region SHALL be H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
REQ-028 vblank and vsync SHALL follow the same rules, applied to vcount with the V parameters.
REQ-029 All outputs SHALL be registered and aligned to the counter values they describe, with zero cycles of skew between hcount/vcount and any flag.
REQ-030 IRQ state machine SHALL have two states, IDLE (irq_n=1) and PEND (irq_n=0).
REQ-031 IDLE->PEND SHALL occur on the pix_ce where hcount wraps to 0 and vcount becomes IRQ_LINE.
REQ-032 PEND->IDLE SHALL occur on irq_ack.
REQ-033 If irq_ack coincides with a new raise, the raise SHALL win and the state SHALL stay PEND.
REQ-034 irq_ack while IDLE SHALL be ignored.
REQ-035 An unacknowledged IRQ SHALL remain PEND across frames, with no double counting.

Reset
REQ-036 While rst is high at a clk edge, the following SHALL be forced: divider=0, hcount=0, vcount=0, pix_ce=0, line_start=0, frame_start=0, irq_n=1 (IDLE).
REQ-037 Under reset, hblank=0, vblank=0 and de=1, and syncs SHALL be at their inactive level (csync_n=1).
REQ-038 Reset mid-line or mid-frame SHALL abandon the current frame.
REQ-039 The first pix_ce after reset release SHALL occur PIX_DIV clk cycles later and SHALL advance hcount to 1.

Configuration
REQ-040 Macro VTG_IRQ_EN defined: the IRQ state machine and irq_ack SHALL be functional.
REQ-041 Macro VTG_IRQ_EN undefined: irq_n SHALL be tied to 1, irq_ack SHALL be ignored, and no IRQ flops SHALL be generated.
REQ-042 All other behaviour SHALL be identical with and without VTG_IRQ_EN.

Structure
REQ-043 Package video_pkg SHALL hold the default timing localparams, a vtg_timing_t struct (active/fp/sync/bp) and a function computing the total.
REQ-044 One sub-module, vtg_axis_counter, SHALL be instantiated twice (horizontal and vertical).
REQ-045 vtg_axis_counter SHALL provide a counter with enable, wrap strobe, and blank/sync decode, parametrised by vtg_timing_t.
REQ-046 Elaboration SHALL fail if PIX_DIV<1, IRQ_LINE>=V_TOTAL, or any porch or sync width is 0.

Verification
REQ-047 Defaults, run 2 frames -> pix_ce period 8 clk; line 384 pixels; frame 264 lines = 811008 clk; de high for 256x224 pixels per frame.
REQ-048 Defaults -> hsync low for hcount 288..319, vsync low for vcount 240..247, csync_n low during either.
REQ-049 Defaults, never ack -> irq_n falls at vcount=224,hcount=0 and stays low through the next frame; then pulse irq_ack -> irq_n=1 the next clk.
REQ-050 irq_ack on the same clk as the raise at line 224 -> irq_n stays 0.
REQ-051 Assert rst at vcount=100,hcount=50 for 3 clk -> all outputs take their reset values; 8 clk after release, hcount=1 and vcount=0.
REQ-052 PIX_DIV=1, HS_POL=1, VTG_IRQ_EN undefined -> pix_ce constantly high, hsync high for hcount 288..319, irq_n constantly 1.
